uart_mulrx: RTL and testbench

Multi-byte UART receiver, the receive-side counterpart of the team's multi-byte UART transmitter. It samples the serial `uartrx` line (8N1, LSB first) and assembles `MUL_RX_NUM` consecutive bytes into one wide word. The first byte received lands in `odats[7:0]`, matching the transmitter's send order. It sits between the board's RX pin and the command decoder, and signals each completed word with a one-cycle `uart_rxs_done` pulse.

---
 rtl/uart_mulrx.sv | 157 +++++++++++++++
 tb/tb_uart_mulrx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_mulrx.sv
// Multi-byte 8N1 UART receiver: assembles MUL_RX_NUM bytes (first byte in odats[7:0]).
// Optional inter-byte idle timeout enabled by defining UART_MULRX_TIMEOUT_EN.
module uart_mulrx #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int UART_BAUD    = 115200,
    parameter int MUL_RX_NUM   = 3,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    uartrx,
    output logic [MUL_RX_NUM*8-1:0] odats,
    output logic                    uart_rxs_done,
    output logic                    frame_err
);

    localparam int BAUD_CNT = SYS_CLK_FREQ / UART_BAUD;
    localparam int HALF     = BAUD_CNT / 2;
    localparam int CW       = $clog2(BAUD_CNT);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [7:0]    LAST_SLOT = 8'(MUL_RX_NUM - 1);

    if (MUL_RX_NUM < 1 || MUL_RX_NUM > 255 || TIMEOUT_BITS < 1 || HALF < 2) begin : g_param_check
        $error("uart_mulrx: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state;
    logic [CW-1:0]           baud_cnt;
    logic [2:0]              bit_idx;
    logic [7:0]              shift;
    logic [7:0]              byte_cnt;
    logic [MUL_RX_NUM*8-1:0] asm_q;
    logic [MUL_RX_NUM*8-1:0] asm_next;
    logic                    rx_meta;
    logic                    rxs;
    logic                    rxs_d;
    logic                    start_edge;

    // Idle-high line: synchronizer resets to 1 so release of reset is not seen as a start edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value of its source.
            rx_meta <= uartrx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign start_edge = rxs_d & ~rxs;

    always_comb begin
        // NOTE: default first, so no path through this block leaves asm_next unassigned (no latch).
        asm_next = asm_q;
        for (int i = 0; i < MUL_RX_NUM; i++) begin
            if (byte_cnt == 8'(i)) asm_next[8*i +: 8] = shift;
        end
    end

`ifdef UART_MULRX_TIMEOUT_EN
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * BAUD_CNT;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYC);

    logic [TW-1:0] idle_cnt;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            byte_cnt      <= '0;
            asm_q         <= '0;
            odats         <= '0;
            uart_rxs_done <= 1'b0;
            frame_err     <= 1'b0;
`ifdef UART_MULRX_TIMEOUT_EN
            idle_cnt      <= '0;
`endif
        end else begin
            uart_rxs_done <= 1'b0;
            frame_err     <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (start_edge) state <= START;
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rxs ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rxs, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (rxs) begin
                            asm_q <= asm_next;
                            if (byte_cnt == LAST_SLOT) begin
                                odats         <= asm_next;
                                uart_rxs_done <= 1'b1;
                                byte_cnt      <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef UART_MULRX_TIMEOUT_EN
            // A stalled partial word is dropped once the line has idled too long.
            if (state == IDLE && !start_edge && byte_cnt != 8'd0) begin
                if (idle_cnt == TIMEOUT_LIMIT) begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_mulrx.sv
// Scoreboarded bench for uart_mulrx: stimulus pushes expected words/errors, a monitor pops on each pulse.
// Runs at 1 Mbaud (50 clocks per bit) to keep simulation short.
module tb_uart_mulrx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD_R   = 1_000_000;
    localparam int BAUD     = CLK_FREQ / BAUD_R;
    localparam int N        = 3;

    logic            sys_clk = 1'b0;
    logic            rst_n   = 1'b0;
    logic            uartrx  = 1'b1;
    logic [N*8-1:0]  odats;
    logic            uart_rxs_done;
    logic            frame_err;

    typedef struct {
        bit             is_err;
        logic [N*8-1:0] word;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] part_q[$];
    int         done_times[$];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;

    uart_mulrx #(
        .SYS_CLK_FREQ(CLK_FREQ),
        .UART_BAUD   (BAUD_R),
        .MUL_RX_NUM  (N),
        .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .uartrx       (uartrx),
        .odats        (odats),
        .uart_rxs_done(uart_rxs_done),
        .frame_err    (frame_err)
    );

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: a received byte list that becomes a word after N good bytes.
    task automatic model_byte(input logic [7:0] b, input bit good);
        ev_t e;
        if (!good) begin
            part_q.delete();
            e.is_err = 1'b1;
            e.word   = '0;
            exp_q.push_back(e);
        end else begin
            part_q.push_back(b);
            if (part_q.size() == N) begin
                e.is_err = 1'b0;
                e.word   = '0;
                for (int i = 0; i < N; i++) e.word[8*i +: 8] = part_q[i];
                exp_q.push_back(e);
                part_q.delete();
            end
        end
    endtask

    task automatic drive_bit(input logic b);
        uartrx = b;
        repeat (BAUD) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1);
`ifdef UART_MULRX_TIMEOUT_EN
        if (n >= 22) part_q.delete();
`endif
    endtask

    // Monitor: every output pulse is matched against the head of the expectation queue.
    always @(negedge sys_clk) begin
        ev_t e;
        if (rst_n && (uart_rxs_done || frame_err)) begin
            if (uart_rxs_done) done_times.push_back(cyc);
            check("event_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("event_kind_err", frame_err, e.is_err);
                check("event_kind_done", uart_rxs_done, !e.is_err);
                if (!e.is_err) check("odats", odats, e.word);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge sys_clk);
        check("reset_odats", odats, 0);
        check("reset_done", uart_rxs_done, 0);
        check("reset_ferr", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Basic word
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
        idle_bits(2);
        check("basic_odats", odats, 24'h332211);

        // Glitch shorter than half a bit
        uartrx = 1'b0;
        repeat (BAUD / 2 - 10) @(negedge sys_clk);
        idle_bits(2);
        send_byte(8'hA5, 1); send_byte(8'h5A, 1); send_byte(8'hFF, 1);
        idle_bits(2);
        check("glitch_odats", odats, 24'hFF5AA5);

        // Framing error discards the partial word
        send_byte(8'h01, 1); send_byte(8'h02, 0);
        idle_bits(1);
        check("ferr_odats_held", odats, 24'hFF5AA5);
        send_byte(8'h0A, 1); send_byte(8'h0B, 1); send_byte(8'h0C, 1);
        idle_bits(2);
        check("ferr_recover_odats", odats, 24'h0C0B0A);

        // Long inter-byte gap
        send_byte(8'h77, 1);
        idle_bits(25);
        send_byte(8'h44, 1); send_byte(8'h55, 1); send_byte(8'h66, 1);
        idle_bits(2);
`ifdef UART_MULRX_TIMEOUT_EN
        check("timeout_odats", odats, 24'h665544);
`else
        check("no_timeout_odats", odats, 24'h554477);
`endif

        // Reset during bit 4 of the second byte
        send_byte(8'h01, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        uartrx = 1'b0;
        repeat (BAUD / 2) @(negedge sys_clk);
        rst_n  = 1'b0;
        uartrx = 1'b1;
        part_q.delete();
        repeat (3) @(negedge sys_clk);
        check("midreset_odats", odats, 0);
        check("midreset_done", uart_rxs_done, 0);
        check("midreset_ferr", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("postreset_odats", odats, 0);
        send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h30, 1);
        idle_bits(2);
        check("postreset_word", odats, 24'h302010);

        // Back-to-back words, zero idle bits
        done_times.delete();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1);
        idle_bits(2);
        check("b2b_count", done_times.size(), 2);
        if (done_times.size() == 2)
            check("b2b_spacing", done_times[1] - done_times[0], 30 * BAUD);
        check("b2b_last", odats, 24'h060504);

        // Random traffic with occasional framing errors and short gaps
        for (int i = 0; i < 24; i++) begin
            bit         ok;
            logic [7:0] b;
            ok = ($urandom_range(7) != 0);
            b  = 8'($urandom);
            send_byte(b, ok);
            idle_bits(ok ? int'($urandom_range(2)) : 1 + int'($urandom_range(2)));
        end

        idle_bits(3);
        check("exp_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
